// File: rtl/tilexy_fiq_responder.sv
// tilexy_fiq_responder
//   Responder end of the tile forward-in-queue (fiq) interface. Requests from
//   the tile cluster FIFO are queued, then looked up one at a time in a small
//   fully associative line store. Read hits are answered locally. Read misses
//   are forwarded to the home tile taken from addr[3:0], or answered as a
//   home-miss when this tile is home. Writebacks update or install lines and
//   produce no response.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-low reset
//   fiq_en              request valid
//   fiq_addr[36:0]      line address, home XY = {addr[3:2] Y, addr[1:0] X}
//   fiq_want_shared     shared read request
//   fiq_want_exclusive  exclusive read request (beats shared)
//   fiq_wb              writeback (beats both read kinds)
//   fiq_data_out[527:0] writeback data
//   fiq_phy_fwd[39:0]   request physical tag
//   fiq_en_in           response/forward valid, one-cycle pulse
//   fiq_data[527:0]     response line data
//   fiq_phy[39:0]       response physical tag
//   fiq_fwd             1 = forward to fiq_fwd_XY, 0 = local data response
//   fiq_fwd_XY[3:0]     forward destination {Y, X}
//   fiq_addr_fwd        request address replicated four times
//   fiq_hit             response came from the line store
//   fiq_busy            request queue full
//   fiq_ovf             sticky: a request arrived while full
module tilexy_fiq_responder #(
  parameter int tile_X = 0,
  parameter int tile_Y = 0,
  parameter int IDX    = 0,
  parameter int DEPTH  = 4,
  parameter int LINES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fiq_en,
  input  logic [36:0]       fiq_addr,
  input  logic              fiq_want_shared,
  input  logic              fiq_want_exclusive,
  input  logic              fiq_wb,
  input  logic [527:0]      fiq_data_out,
  input  logic [39:0]       fiq_phy_fwd,
  output logic              fiq_en_in,
  output logic [527:0]      fiq_data,
  output logic [39:0]       fiq_phy,
  output logic              fiq_fwd,
  output logic [3:0]        fiq_fwd_XY,
  output logic [3:0][36:0]  fiq_addr_fwd,
  output logic              fiq_hit,
  output logic              fiq_busy,
  output logic              fiq_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(LINES);
  localparam logic [3:0] OWN_XY = 4'(((tile_Y % 4) * 4) + (tile_X % 4));

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end
  if (LINES < 2 || LINES > 16 || (LINES & (LINES - 1)) != 0) begin : g_bad_lines
    $error("LINES must be a power of two in 2..16");
  end
  if (IDX < 0) begin : g_bad_idx
    $error("IDX must be non-negative");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESPOND
  } state_t;

  typedef enum logic [1:0] {
    K_NONE   = 2'd0,
    K_SHARED = 2'd1,
    K_EXCL   = 2'd2,
    K_WB     = 2'd3
  } kind_t;

  state_t state, state_nxt;

  // ---------------- request queue ----------------
  logic [36:0]   q_addr [DEPTH];
  kind_t         q_kind [DEPTH];
  logic [527:0]  q_data [DEPTH];
  logic [39:0]   q_phy  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;
  kind_t         in_kind;

  // A request with no kind bit set is stored as shared.
  always_comb begin
    in_kind = K_SHARED;
    if (fiq_wb)                  in_kind = K_WB;
    else if (fiq_want_exclusive) in_kind = K_EXCL;
  end

  assign push = fiq_en && !fiq_busy;
  assign pop  = (state == ST_IDLE) && (count != '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fiq_busy <= 1'b0;
      fiq_ovf  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      fiq_busy <= (count_nxt == (AW+1)'(DEPTH));
      if (fiq_en && fiq_busy) fiq_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= fiq_addr;
      q_kind[wr_ptr] <= in_kind;
      q_data[wr_ptr] <= fiq_data_out;
      q_phy[wr_ptr]  <= fiq_phy_fwd;
    end
  end

  // ---------------- holding register ----------------
  logic [36:0]  h_addr;
  kind_t        h_kind;
  logic [527:0] h_data;
  logic [39:0]  h_phy;

  always_ff @(posedge clk) begin
    if (pop) begin
      h_addr <= q_addr[rd_ptr];
      h_kind <= q_kind[rd_ptr];
      h_data <= q_data[rd_ptr];
      h_phy  <= q_phy[rd_ptr];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pop) state_nxt = ST_LOOKUP;
      ST_LOOKUP:  state_nxt = (h_kind == K_WB) ? ST_IDLE : ST_RESPOND;
      ST_RESPOND: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- line store ----------------
  logic [LINES-1:0] ln_valid;
  logic [36:0]      ln_addr [LINES];
  logic [527:0]     ln_data [LINES];
  logic [39:0]      ln_phy  [LINES];
  logic [LW-1:0]    rr;
  logic             hit, inv_found;
  logic [LW-1:0]    hit_idx, inv_idx, wb_idx;
  logic             is_lookup, is_wb, ln_write;

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (!hit && ln_valid[i] && (ln_addr[i] == h_addr)) begin
        hit     = 1'b1;
        hit_idx = LW'(i);
      end
      if (!inv_found && !ln_valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = LW'(i);
      end
    end
  end

  assign is_lookup = (state == ST_LOOKUP);
  assign is_wb     = (h_kind == K_WB);
  assign ln_write  = is_lookup && is_wb;

  // Writeback target: existing copy, else lowest free slot, else RR victim.
  always_comb begin
    wb_idx = rr;
    if (hit)            wb_idx = hit_idx;
    else if (inv_found) wb_idx = inv_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ln_valid <= '0;
      rr       <= '0;
    end else if (is_lookup) begin
      if (is_wb) begin
        ln_valid[wb_idx] <= 1'b1;
        if (!hit && !inv_found) rr <= rr + LW'(1);
      end else if (hit && (h_kind == K_EXCL)) begin
        ln_valid[hit_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ln_write) begin
      ln_addr[wb_idx] <= h_addr;
      ln_data[wb_idx] <= h_data;
      ln_phy[wb_idx]  <= h_phy;
    end
  end

  // ---------------- response ----------------
  // Fields are latched at the LOOKUP edge so they are stable during RESPOND
  // and hold afterwards; fiq_en_in is high exactly for the RESPOND cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fiq_en_in    <= 1'b0;
      fiq_data     <= '0;
      fiq_phy      <= '0;
      fiq_fwd      <= 1'b0;
      fiq_fwd_XY   <= '0;
      fiq_addr_fwd <= '0;
      fiq_hit      <= 1'b0;
    end else begin
      fiq_en_in <= is_lookup && !is_wb;
      if (is_lookup && !is_wb) begin
        fiq_addr_fwd <= {4{h_addr}};
        fiq_fwd_XY   <= h_addr[3:0];
        if (hit) begin
          fiq_fwd  <= 1'b0;
          fiq_hit  <= 1'b1;
          fiq_data <= ln_data[hit_idx];
          fiq_phy  <= ln_phy[hit_idx];
        end else begin
          fiq_fwd  <= (h_addr[3:0] != OWN_XY);
          fiq_hit  <= 1'b0;
          fiq_data <= '0;
          fiq_phy  <= h_phy;
        end
      end
    end
  end

endmodule
